// File: rtl/console_ctrl_if.sv
// Byte-stream input and VRAM write-port bundle for console_ctrl.
interface console_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              ram_ce;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic [ADDR_W-1:0] cursor_addr;
  logic              busy;

  modport master (
    output char_valid, char_data,
    input  char_ready, ram_ce, ram_addr, ram_data, cursor_addr, busy
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, ram_ce, ram_addr, ram_data, cursor_addr, busy
  );
endinterface

// File: rtl/console_ctrl.sv
// Text-console sequencer: interprets a byte stream and writes {ATTR, char} cells to VRAM.
// Screen clear on FF is built only when CONSOLE_CTRL_CLEAR_EN is defined.
module console_ctrl #(
  parameter int         COLS       = 50,
  parameter int         ROWS       = 15,
  parameter int         ADDR_W     = 12,
  parameter logic [7:0] ATTR       = 8'hf0,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic          clk,
  input  logic          reset,
  console_ctrl_if.slave bus
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0]     COL_ZERO  = CW'(0);
  localparam logic [CW-1:0]     COL_ONE   = CW'(1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_ZERO  = RW'(0);
  localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] A_ZERO    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_COLS    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_LASTROW = ADDR_W'((ROWS - 1) * COLS);
`ifdef CONSOLE_CTRL_CLEAR_EN
  localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(COLS * ROWS - 1);
`endif

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0a;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LO = 8'h20;
  localparam logic [7:0] CH_HI = 8'h7e;
`ifdef CONSOLE_CTRL_CLEAR_EN
  localparam logic [7:0] CH_FF = 8'h0c;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1
`ifdef CONSOLE_CTRL_CLEAR_EN
    , S_CLEAR = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic              ce_q, ce_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              ready_q, ready_d;
`ifdef CONSOLE_CTRL_CLEAR_EN
  logic              busy_q, busy_d;
`endif
  logic              accept_s;
  logic              printable_s;

  assign accept_s    = bus.char_valid && ready_q;
  assign printable_s = (bus.char_data >= CH_LO) && (bus.char_data <= CH_HI);

  // Next-state, cursor arithmetic and output-register next values.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cur_d   = cur_q;
    ce_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ready_d = 1'b0;
`ifdef CONSOLE_CTRL_CLEAR_EN
    busy_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept_s) begin
          if (printable_s) begin
            state_d = S_WRITE;
            ce_d    = 1'b1;
            ready_d = 1'b0;
            addr_d  = cur_q;
            data_d  = {ATTR, bus.char_data};
          end else if (bus.char_data == CH_CR) begin
            col_d = COL_ZERO;
            cur_d = cur_q - ADDR_W'(col_q);
          end else if (bus.char_data == CH_LF) begin
            if (row_q == ROW_LAST) begin
              row_d = ROW_ZERO;
              cur_d = cur_q - A_LASTROW;
            end else begin
              row_d = row_q + ROW_ONE;
              cur_d = cur_q + A_COLS;
            end
          end else if (bus.char_data == CH_BS) begin
            if (col_q != COL_ZERO) begin
              col_d = col_q - COL_ONE;
              cur_d = cur_q - A_ONE;
            end else begin
              col_d = col_q;
            end
`ifdef CONSOLE_CTRL_CLEAR_EN
          end else if (bus.char_data == CH_FF) begin
            state_d = S_CLEAR;
            ce_d    = 1'b1;
            ready_d = 1'b0;
            busy_d  = 1'b1;
            addr_d  = A_ZERO;
            data_d  = {ATTR, CLEAR_CHAR};
`endif
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        // Column and row wrap together; the linear address wraps only at the last cell.
        if (col_q == COL_LAST) begin
          col_d = COL_ZERO;
          if (row_q == ROW_LAST) begin
            row_d = ROW_ZERO;
            cur_d = A_ZERO;
          end else begin
            row_d = row_q + ROW_ONE;
            cur_d = cur_q + A_ONE;
          end
        end else begin
          col_d = col_q + COL_ONE;
          cur_d = cur_q + A_ONE;
        end
      end
`ifdef CONSOLE_CTRL_CLEAR_EN
      S_CLEAR: begin
        if (addr_q == A_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          row_d   = ROW_ZERO;
          col_d   = COL_ZERO;
          cur_d   = A_ZERO;
        end else begin
          ce_d    = 1'b1;
          busy_d  = 1'b1;
          addr_d  = addr_q + A_ONE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= ROW_ZERO;
      col_q   <= COL_ZERO;
      cur_q   <= A_ZERO;
      ce_q    <= 1'b0;
      addr_q  <= A_ZERO;
      data_q  <= 16'h0000;
      ready_q <= 1'b1;
`ifdef CONSOLE_CTRL_CLEAR_EN
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cur_q   <= cur_d;
      ce_q    <= ce_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
`ifdef CONSOLE_CTRL_CLEAR_EN
      busy_q  <= busy_d;
`endif
    end
  end

  assign bus.char_ready  = ready_q;
  assign bus.ram_ce      = ce_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_data    = data_q;
  assign bus.cursor_addr = cur_q;
`ifdef CONSOLE_CTRL_CLEAR_EN
  assign bus.busy        = busy_q;
`else
  assign bus.busy        = 1'b0;
`endif
endmodule

// File: tb/tb_console_ctrl.sv
// Self-checking bench for console_ctrl: vector table, corner sequences and a random run vs. a cursor model.
module tb_console_ctrl;
  localparam int         COLS = 50;
  localparam int         ROWS = 15;
  localparam int         N    = COLS * ROWS;
  localparam logic [7:0] ATTR = 8'hf0;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   pos;
  int   last_addr;
  int   last_data;

  console_ctrl_if #(.ADDR_W(12)) bus ();

  console_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .ATTR(ATTR), .CLEAR_CHAR(8'h20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         we;
    int         addr;
    int         cur;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // No write may ever leave the visible screen.
  always @(negedge clk) begin
    if (reset && bus.ram_ce) begin
      total++;
      if (int'(bus.ram_addr) >= N) begin
        bad++;
        $display("FAIL addr_range: got %0d expected below %0d", bus.ram_addr, N);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pos = 0;
    last_addr = 0;
    last_data = 0;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready_wait"}, bus.char_ready, 1);
  endtask

  task automatic xact(input logic [7:0] b, input bit ewe, input int eaddr, input int ecur,
                      input string nm);
    logic [15:0] edata;
    edata = {ATTR, b};
    wait_ready(nm);
    bus.char_valid = 1'b1;
    bus.char_data  = b;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'($urandom);
    chk({nm, " ce"}, bus.ram_ce, ewe);
    if (ewe) begin
      chk({nm, " addr"}, bus.ram_addr, eaddr);
      chk({nm, " data"}, bus.ram_data, edata);
      chk({nm, " ready_low"}, bus.char_ready, 0);
      chk({nm, " cursor_hold"}, bus.cursor_addr, pos);
      @(posedge clk);
      #1;
      chk({nm, " ce_drop"}, bus.ram_ce, 0);
      last_addr = eaddr;
      last_data = edata;
    end else begin
      chk({nm, " addr_hold"}, bus.ram_addr, last_addr);
      chk({nm, " data_hold"}, bus.ram_data, last_data);
    end
    chk({nm, " ready"}, bus.char_ready, 1);
    chk({nm, " cursor"}, bus.cursor_addr, ecur);
    pos = ecur;
  endtask

  // Reference: cursor as a linear position, row/col derived by division.
  task automatic send_model(input logic [7:0] b, input string nm);
    int r, c, np;
    bit we;
    r  = pos / COLS;
    c  = pos % COLS;
    we = (b >= 8'h20) && (b <= 8'h7e);
    np = pos;
    if (we) np = (pos + 1) % N;
    else if (b == 8'h0d) np = r * COLS;
    else if (b == 8'h0a) np = ((r + 1) % ROWS) * COLS + c;
    else if (b == 8'h08 && c > 0) np = pos - 1;
    xact(b, we, pos, np, nm);
  endtask

  vec_t tbl[20];

  initial begin
    int errs;
    logic [7:0] b;
    total = 0;
    bad   = 0;
    tbl[0]  = '{8'h41, 1'b1,   0,   1};
    tbl[1]  = '{8'h0a, 1'b0,   0,  51};
    tbl[2]  = '{8'h0a, 1'b0,   0, 101};
    tbl[3]  = '{8'h08, 1'b0,   0, 100};
    tbl[4]  = '{8'h61, 1'b1, 100, 101};
    tbl[5]  = '{8'h62, 1'b1, 101, 102};
    tbl[6]  = '{8'h63, 1'b1, 102, 103};
    tbl[7]  = '{8'h58, 1'b1, 103, 104};
    tbl[8]  = '{8'h0d, 1'b0,   0, 100};
    tbl[9]  = '{8'h0a, 1'b0,   0, 150};
    tbl[10] = '{8'h59, 1'b1, 150, 151};
    tbl[11] = '{8'h07, 1'b0,   0, 151};
    tbl[12] = '{8'h90, 1'b0,   0, 151};
    tbl[13] = '{8'h0d, 1'b0,   0, 150};
    tbl[14] = '{8'h08, 1'b0,   0, 150};
    tbl[15] = '{8'h7f, 1'b0,   0, 150};
    tbl[16] = '{8'h7e, 1'b1, 150, 151};
    tbl[17] = '{8'h20, 1'b1, 151, 152};
    tbl[18] = '{8'h1f, 1'b0,   0, 152};
    tbl[19] = '{8'h08, 1'b0,   0, 151};

    do_reset();
    #1;
    chk("rst ready", bus.char_ready, 1);
    chk("rst ce", bus.ram_ce, 0);
    chk("rst addr", bus.ram_addr, 0);
    chk("rst data", bus.ram_data, 0);
    chk("rst cursor", bus.cursor_addr, 0);
    chk("rst busy", bus.busy, 0);

    for (int i = 0; i < 20; i++) begin
      xact(tbl[i].data, tbl[i].we, tbl[i].addr, tbl[i].cur, $sformatf("vec%0d", i));
    end

    // Full-screen wrap: 751 printables end with the cursor at 1.
    do_reset();
    for (int i = 0; i < N + 1; i++) begin
      send_model(8'($urandom_range(32, 126)), "wrap");
    end
    chk("wrap final cursor", bus.cursor_addr, 1);

    // LF on the last row wraps to row 0, keeping the column.
    do_reset();
    for (int i = 0; i < 5; i++) send_model(8'h41, "lf_pre");
    for (int i = 0; i < ROWS - 1; i++) send_model(8'h0a, "lf_down");
    chk("lf row14 col5", bus.cursor_addr, 705);
    send_model(8'h0a, "lf_wrap");
    chk("lf wrap cursor", bus.cursor_addr, 5);

    // BS at column 0 of row 1 holds; BS at 52 goes to 51.
    do_reset();
    send_model(8'h0a, "bs_pre");
    send_model(8'h08, "bs_col0");
    chk("bs col0 cursor", bus.cursor_addr, 50);
    send_model(8'h41, "bs_a");
    send_model(8'h42, "bs_b");
    send_model(8'h08, "bs_52");
    chk("bs 52 cursor", bus.cursor_addr, 51);

    // FF at cursor 300.
    do_reset();
    for (int i = 0; i < 6; i++) send_model(8'h0a, "ff_pre");
    chk("ff pre cursor", bus.cursor_addr, 300);
`ifdef CONSOLE_CTRL_CLEAR_EN
    wait_ready("ff");
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0c;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    errs = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.ram_ce !== 1'b1 || int'(bus.ram_addr) != i || bus.ram_data !== 16'hf020 ||
          bus.busy !== 1'b1 || bus.char_ready !== 1'b0) errs++;
      @(posedge clk);
      #1;
    end
    chk("clear cycle errors", errs, 0);
    chk("clear ce end", bus.ram_ce, 0);
    chk("clear busy end", bus.busy, 0);
    chk("clear ready end", bus.char_ready, 1);
    chk("clear cursor end", bus.cursor_addr, 0);
    pos = 0;
    last_addr = N - 1;
    last_data = 16'hf020;
    send_model(8'h43, "after_clear");
`else
    send_model(8'h0c, "ff_ignored");
    chk("ff ignored cursor", bus.cursor_addr, 300);
    chk("ff busy", bus.busy, 0);
`endif

    // Reset in the middle of a write.
    do_reset();
    for (int i = 0; i < 3; i++) send_model(8'h41, "mw_pre");
    wait_ready("mw");
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h51;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    chk("mw ce before", bus.ram_ce, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mw ce async", bus.ram_ce, 0);
    chk("mw cursor async", bus.cursor_addr, 0);
    chk("mw addr async", bus.ram_addr, 0);
    chk("mw ready async", bus.char_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    pos = 0;
    last_addr = 0;
    last_data = 0;
    send_model(8'h42, "mw_b");

`ifdef CONSOLE_CTRL_CLEAR_EN
    // Reset during the 100th clear cycle.
    do_reset();
    send_model(8'h41, "mc_pre");
    wait_ready("mc");
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0c;
    @(posedge clk);
    #1;
    bus.char_valid = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("mc addr 100th", bus.ram_addr, 99);
    chk("mc busy 100th", bus.busy, 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mc ce async", bus.ram_ce, 0);
    chk("mc cursor async", bus.cursor_addr, 0);
    chk("mc busy async", bus.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    pos = 0;
    last_addr = 0;
    last_data = 0;
    chk("mc ready after", bus.char_ready, 1);
    send_model(8'h42, "mc_b");
`endif

    // Random stream against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: b = 8'($urandom_range(32, 126));
        5:             b = 8'h0d;
        6:             b = 8'h0a;
        7, 8:          b = 8'h08;
        default:       b = 8'($urandom);
      endcase
`ifdef CONSOLE_CTRL_CLEAR_EN
      if (b == 8'h0c) b = 8'h0b;
`endif
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_model(b, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
